// File: rtl/multicycle_controller.sv
// Multi-cycle MIPS control FSM: sequences each instruction through
// FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK, handshakes with the unified memory
// port via mem_req/mem_ready, and traps on illegal opcodes or memory timeout.
//
//   state     | meaning
//   ----------+-------------------------------------------------------------
//   FETCH     | request instruction word; load IR and PC+4 on mem_ready
//   DECODE    | latch opcode/func; resolve j/jr, send jal to writeback
//   EXECUTE   | drive ALU controls; resolve branches
//   MEMORY    | data access for lw/sw, wait for mem_ready
//   WRITEBACK | single register-file write (and jal PC update)
//   TRAP      | illegal opcode or memory timeout; left only through reset
module multicycle_controller #(
  parameter int OP_WIDTH      = 6,
  parameter int FUNC_WIDTH    = 6,
  parameter int TIMEOUT_WIDTH = 8,
  parameter int MEM_TIMEOUT   = 200
) (
  input  logic                  clock,
  input  logic                  rst_n,
  input  logic [OP_WIDTH-1:0]   opcode,
  input  logic [FUNC_WIDTH-1:0] func,
  input  logic                  zero,
  input  logic                  mem_ready,
  output logic                  mem_req,
  output logic                  mem_write,
  output logic                  ir_write,
  output logic                  pc_write,
  output logic [1:0]            pc_src,
  output logic                  reg_write,
  output logic                  reg_dst,
  output logic                  mem_to_reg,
  output logic                  jal,
  output logic                  alu_src,
  output logic [1:0]            alu_op,
  output logic                  sftmd,
  output logic                  retired,
  output logic                  trap,
  output logic [1:0]            trap_cause,
  output logic [2:0]            state
);

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEMORY    = 3'd3,
    S_WRITEBACK = 3'd4,
    S_TRAP      = 3'd7
  } state_t;

  // Last count value before the watchdog fires; the fire cycle is the
  // MEM_TIMEOUT-th consecutive wait cycle in the same state.
  localparam logic [TIMEOUT_WIDTH-1:0] WD_LAST = TIMEOUT_WIDTH'(MEM_TIMEOUT - 1);

  state_t                   state_q, state_d;
  logic [OP_WIDTH-1:0]      op_q;
  logic [FUNC_WIDTH-1:0]    fn_q;
  logic [TIMEOUT_WIDTH-1:0] wd_cnt;
  logic [1:0]               cause_q, enter_cause;
  logic                     wait_cyc, wd_expire;

  function automatic logic op_is(input logic [OP_WIDTH-1:0] op, input logic [5:0] code);
    return op == OP_WIDTH'(code);
  endfunction

  function automatic logic is_ifmt(input logic [OP_WIDTH-1:0] op);
    return op[OP_WIDTH-1 -: 3] == 3'b001;
  endfunction

  function automatic logic is_legal(input logic [OP_WIDTH-1:0] op);
    return op_is(op, 6'h00) | op_is(op, 6'h23) | op_is(op, 6'h2B) |
           op_is(op, 6'h04) | op_is(op, 6'h05) | op_is(op, 6'h02) |
           op_is(op, 6'h03) | is_ifmt(op);
  endfunction

  function automatic logic is_shift(input logic [OP_WIDTH-1:0] op,
                                    input logic [FUNC_WIDTH-1:0] fn);
    return op_is(op, 6'h00) &&
           (fn == FUNC_WIDTH'(6'h00) || fn == FUNC_WIDTH'(6'h02) ||
            fn == FUNC_WIDTH'(6'h03) || fn == FUNC_WIDTH'(6'h04) ||
            fn == FUNC_WIDTH'(6'h06) || fn == FUNC_WIDTH'(6'h07));
  endfunction

  assign state      = state_q;
  assign trap_cause = cause_q;
  assign wait_cyc   = ((state_q == S_FETCH) || (state_q == S_MEMORY)) && !mem_ready;
  assign wd_expire  = (MEM_TIMEOUT != 0) && wait_cyc && (wd_cnt >= WD_LAST);

  // State register.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // Decode latch: later stages see only the IR value present in DECODE.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      op_q <= '0;
      fn_q <= '0;
    end else if (state_q == S_DECODE) begin
      op_q <= opcode;
      fn_q <= func;
    end
  end

  // Memory-wait watchdog: restarts on every state change, saturates.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n)                              wd_cnt <= '0;
    else if (state_d != state_q)             wd_cnt <= '0;
    else if (wait_cyc && (wd_cnt != '1))     wd_cnt <= wd_cnt + 1'b1;
  end

  // Trap cause is captured on TRAP entry and held until reset.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n)                  cause_q <= 2'd0;
    else if (enter_cause != 2'd0) cause_q <= enter_cause;
  end

  // Next-state and per-state datapath enables; everything is held low in reset.
  always_comb begin
    state_d     = state_q;
    enter_cause = 2'd0;
    mem_req     = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    pc_src      = 2'd0;
    reg_write   = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    jal         = 1'b0;
    alu_src     = 1'b0;
    alu_op      = 2'd0;
    sftmd       = 1'b0;
    retired     = 1'b0;
    trap        = 1'b0;
    if (rst_n) begin
      case (state_q)
        S_FETCH: begin
          mem_req = 1'b1;
          if (mem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            state_d  = S_DECODE;
          end else if (wd_expire) begin
            state_d     = S_TRAP;
            enter_cause = 2'd2;
          end
        end
        S_DECODE: begin
          if (!is_legal(opcode)) begin
            state_d     = S_TRAP;
            enter_cause = 2'd1;
          end else if (op_is(opcode, 6'h02)) begin
            pc_write = 1'b1;
            pc_src   = 2'd2;
            retired  = 1'b1;
            state_d  = S_FETCH;
          end else if (op_is(opcode, 6'h00) && (func == FUNC_WIDTH'(6'h08))) begin
            pc_write = 1'b1;
            pc_src   = 2'd3;
            retired  = 1'b1;
            state_d  = S_FETCH;
          end else if (op_is(opcode, 6'h03)) begin
            state_d = S_WRITEBACK;
          end else begin
            state_d = S_EXECUTE;
          end
        end
        S_EXECUTE: begin
          alu_src = is_ifmt(op_q) | op_is(op_q, 6'h23) | op_is(op_q, 6'h2B);
          alu_op  = {op_is(op_q, 6'h00) | is_ifmt(op_q),
                     op_is(op_q, 6'h04) | op_is(op_q, 6'h05)};
          sftmd   = is_shift(op_q, fn_q);
          if (op_is(op_q, 6'h04) || op_is(op_q, 6'h05)) begin
            pc_write = (op_is(op_q, 6'h04) & zero) | (op_is(op_q, 6'h05) & ~zero);
            pc_src   = 2'd1;
            retired  = 1'b1;
            state_d  = S_FETCH;
          end else if (op_is(op_q, 6'h23) || op_is(op_q, 6'h2B)) begin
            state_d = S_MEMORY;
          end else begin
            state_d = S_WRITEBACK;
          end
        end
        S_MEMORY: begin
          mem_req   = 1'b1;
          mem_write = op_is(op_q, 6'h2B);
          if (mem_ready) begin
            if (op_is(op_q, 6'h2B)) begin
              retired = 1'b1;
              state_d = S_FETCH;
            end else begin
              state_d = S_WRITEBACK;
            end
          end else if (wd_expire) begin
            state_d     = S_TRAP;
            enter_cause = 2'd2;
          end
        end
        S_WRITEBACK: begin
          reg_write  = 1'b1;
          reg_dst    = op_is(op_q, 6'h00);
          mem_to_reg = op_is(op_q, 6'h23);
          jal        = op_is(op_q, 6'h03);
          if (op_is(op_q, 6'h03)) begin
            pc_write = 1'b1;
            pc_src   = 2'd2;
          end
          retired = 1'b1;
          state_d = S_FETCH;
        end
        S_TRAP: begin
          trap = 1'b1;
        end
        default: begin
          state_d = S_FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: expected per-cycle output vectors
// are queued for each instruction and popped as the FSM steps through it.
module tb_multicycle_controller;

  logic       clock = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = '0;
  logic [5:0] func = '0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b1;
  logic       mem_req, mem_write, ir_write, pc_write, reg_write, reg_dst;
  logic       mem_to_reg, jal, alu_src, sftmd, retired, trap;
  logic [1:0] pc_src, alu_op, trap_cause;
  logic [2:0] state;

  logic [5:0]  ir_op = '0;
  logic [5:0]  ir_fn = '0;
  logic [20:0] obs;
  int          total = 0;
  int          bad = 0;

  typedef struct {
    string       tag;
    logic [20:0] v;
  } sb_t;
  sb_t sb[$];

  multicycle_controller #(
    .OP_WIDTH(6), .FUNC_WIDTH(6), .TIMEOUT_WIDTH(8), .MEM_TIMEOUT(5)
  ) dut (
    .clock(clock), .rst_n(rst_n), .opcode(opcode), .func(func), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_write(mem_write),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .jal(jal), .alu_src(alu_src), .alu_op(alu_op), .sftmd(sftmd),
    .retired(retired), .trap(trap), .trap_cause(trap_cause), .state(state)
  );

  always #5 clock = ~clock;

  assign obs = {state, mem_req, mem_write, ir_write, pc_write, pc_src,
                reg_write, reg_dst, mem_to_reg, jal, alu_src, alu_op,
                sftmd, retired, trap, trap_cause};

  function automatic logic [20:0] pk(input int st, input logic mreq, input logic mwr,
      input logic irw, input logic pcw, input int pcs, input logic rw, input logic rd,
      input logic m2r, input logic jl, input logic asrc, input int aop,
      input logic sft, input logic ret, input logic trp, input int tc);
    return {st[2:0], mreq, mwr, irw, pcw, pcs[1:0], rw, rd, m2r, jl, asrc,
            aop[1:0], sft, ret, trp, tc[1:0]};
  endfunction

  function automatic logic [20:0] e_zero();
    return pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction
  function automatic logic [20:0] e_fetch(input logic rdy);
    return pk(0, 1, 0, rdy, rdy, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction
  function automatic logic [20:0] e_dec(input logic pcw, input int pcs, input logic ret);
    return pk(1, 0, 0, 0, pcw, pcs, 0, 0, 0, 0, 0, 0, 0, ret, 0, 0);
  endfunction
  function automatic logic [20:0] e_exe(input logic asrc, input int aop, input logic sft,
                                        input logic pcw, input int pcs, input logic ret);
    return pk(2, 0, 0, 0, pcw, pcs, 0, 0, 0, 0, asrc, aop, sft, ret, 0, 0);
  endfunction
  function automatic logic [20:0] e_mem(input logic wr, input logic ret);
    return pk(3, 1, wr, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ret, 0, 0);
  endfunction
  function automatic logic [20:0] e_wb(input logic rd, input logic m2r, input logic jl,
                                       input logic pcw, input int pcs);
    return pk(4, 0, 0, 0, pcw, pcs, 1, rd, m2r, jl, 0, 0, 0, 1, 0, 0);
  endfunction
  function automatic logic [20:0] e_trap(input int tc);
    return pk(7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, tc);
  endfunction

  task automatic push(input string tag, input logic [20:0] v);
    sb_t e;
    e.tag = tag;
    e.v   = v;
    sb.push_back(e);
  endtask

  task automatic check_next();
    sb_t e;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $error("FAIL sb_empty: got %h with nothing expected", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.v) else begin
        bad++;
        $error("FAIL %s: got %h expected %h", e.tag, obs, e.v);
      end
    end
  endtask

  // One clock cycle: drive inputs after the falling edge, compare before the rising edge.
  task automatic step(input logic mr, input logic z);
    @(negedge clock);
    mem_ready = mr;
    zero      = z;
    opcode    = ir_op;
    func      = ir_fn;
    #1;
    check_next();
  endtask

  // Release lands just after a rising edge so the first stepped cycle is a fresh FETCH.
  task automatic do_reset();
    rst_n     = 1'b0;
    mem_ready = 1'b0;
    zero      = 1'b0;
    repeat (2) @(posedge clock);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    // reset with memory claiming ready: outputs must all stay low
    #2;
    push("reset_state", e_zero());
    check_next();
    do_reset();

    // add, IR overwritten after DECODE to prove the latched copy is used
    ir_op = 6'h00; ir_fn = 6'h20;
    push("add_f", e_fetch(1)); push("add_d", e_dec(0, 0, 0));
    push("add_e", e_exe(0, 2, 0, 0, 0, 0)); push("add_wb", e_wb(1, 0, 0, 0, 0));
    push("next_f", e_fetch(1));
    step(1, 0); step(1, 0);
    ir_op = 6'h3F; ir_fn = 6'h00;
    step(1, 0); step(1, 0);
    ir_op = 6'h23;
    step(1, 0);

    // lw with memory stalling three cycles (fetch above already started it)
    push("lw_d", e_dec(0, 0, 0)); push("lw_e", e_exe(1, 0, 0, 0, 0, 0));
    for (int i = 0; i < 3; i++) push("lw_mwait", e_mem(0, 0));
    push("lw_mdone", e_mem(0, 0)); push("lw_wb", e_wb(0, 1, 0, 0, 0));
    step(1, 0); step(1, 0);
    step(0, 0); step(0, 0); step(0, 0); step(1, 0);
    step(1, 0);

    // sw, zero wait
    ir_op = 6'h2B;
    push("sw_f", e_fetch(1)); push("sw_d", e_dec(0, 0, 0));
    push("sw_e", e_exe(1, 0, 0, 0, 0, 0)); push("sw_m", e_mem(1, 1));
    repeat (4) step(1, 0);

    // beq taken / not taken, bne taken
    ir_op = 6'h04;
    push("beq_f", e_fetch(1)); push("beq_d", e_dec(0, 0, 0));
    push("beq_taken", e_exe(0, 1, 0, 1, 1, 1));
    step(1, 0); step(1, 0); step(1, 1);
    push("beq_f2", e_fetch(1)); push("beq_d2", e_dec(0, 0, 0));
    push("beq_not", e_exe(0, 1, 0, 0, 1, 1));
    step(1, 1); step(1, 1); step(1, 0);
    ir_op = 6'h05;
    push("bne_f", e_fetch(1)); push("bne_d", e_dec(0, 0, 0));
    push("bne_taken", e_exe(0, 1, 0, 1, 1, 1));
    step(1, 1); step(1, 1); step(1, 0);

    // jal, jr, j
    ir_op = 6'h03;
    push("jal_f", e_fetch(1)); push("jal_d", e_dec(0, 0, 0));
    push("jal_wb", e_wb(0, 0, 1, 1, 2));
    repeat (3) step(1, 0);
    ir_op = 6'h00; ir_fn = 6'h08;
    push("jr_f", e_fetch(1)); push("jr_d", e_dec(1, 3, 1));
    repeat (2) step(1, 0);
    ir_op = 6'h02;
    push("j_f", e_fetch(1)); push("j_d", e_dec(1, 2, 1));
    repeat (2) step(1, 0);

    // sll (shift) and addi (I-format)
    ir_op = 6'h00; ir_fn = 6'h00;
    push("sll_f", e_fetch(1)); push("sll_d", e_dec(0, 0, 0));
    push("sll_e", e_exe(0, 2, 1, 0, 0, 0)); push("sll_wb", e_wb(1, 0, 0, 0, 0));
    repeat (4) step(1, 0);
    ir_op = 6'h08; ir_fn = 6'h20;
    push("addi_f", e_fetch(1)); push("addi_d", e_dec(0, 0, 0));
    push("addi_e", e_exe(1, 2, 0, 0, 0, 0)); push("addi_wb", e_wb(0, 0, 0, 0, 0));
    repeat (4) step(1, 0);

    // illegal opcode: trap and stay for 50 cycles
    ir_op = 6'h3F;
    push("ill_f", e_fetch(1)); push("ill_d", e_dec(0, 0, 0));
    for (int i = 0; i < 50; i++) push("ill_trap", e_trap(1));
    step(1, 0); step(1, 0);
    for (int i = 0; i < 50; i++) step(logic'(i % 2), 0);
    do_reset();

    // fetch timeout after five wait cycles
    ir_op = 6'h00; ir_fn = 6'h20;
    for (int i = 0; i < 5; i++) push("to_wait", e_fetch(0));
    for (int i = 0; i < 3; i++) push("to_trap", e_trap(2));
    repeat (5) step(0, 0);
    repeat (3) step(1, 0);
    do_reset();

    // ready on the fifth wait cycle wins over the watchdog
    for (int i = 0; i < 4; i++) push("near_wait", e_fetch(0));
    push("near_f", e_fetch(1)); push("near_d", e_dec(0, 0, 0));
    push("near_e", e_exe(0, 2, 0, 0, 0, 0)); push("near_wb", e_wb(1, 0, 0, 0, 0));
    repeat (4) step(0, 0);
    repeat (4) step(1, 0);

    // reset asserted in the middle of a MEMORY wait
    ir_op = 6'h23;
    push("mr_f", e_fetch(1)); push("mr_d", e_dec(0, 0, 0));
    push("mr_e", e_exe(1, 0, 0, 0, 0, 0)); push("mr_m", e_mem(0, 0));
    step(1, 0); step(1, 0); step(1, 0); step(0, 0);
    #2;
    rst_n     = 1'b0;
    mem_ready = 1'b1;
    #1;
    push("mr_async_rst", e_zero());
    check_next();
    do_reset();
    ir_op = 6'h00; ir_fn = 6'h20;
    push("post_f", e_fetch(1)); push("post_d", e_dec(0, 0, 0));
    push("post_e", e_exe(0, 2, 0, 0, 0, 0)); push("post_wb", e_wb(1, 0, 0, 0, 0));
    repeat (4) step(1, 0);

    total++;
    assert (sb.size() == 0) else begin
      bad++;
      $error("FAIL sb_leftover: got %0d entries expected 0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Parametrised multi-cycle successor to the single-cycle main decoder.
- Sequences each MIPS instruction through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK states.
- Handshakes with instruction/data memory through a req/ready pair, with a watchdog timeout.
- Sits between the IR/ALU datapath and the unified memory port, and drives all datapath enables per state.

Parameters:
- OP_WIDTH, 6, opcode field width.
- FUNC_WIDTH, 6, function field width.
- TIMEOUT_WIDTH, 8, width of the memory-wait watchdog counter.
- MEM_TIMEOUT, 200, maximum cycles to wait for mem_ready before trapping; 0 disables the watchdog.

Ports:
- clock  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  OP_WIDTH  IR[31:26].
- func  in  FUNC_WIDTH  IR[5:0].
- zero  in  1  ALU zero flag, valid in EXECUTE.
- mem_ready  in  1  memory completed the request this cycle.
- mem_req  out  1  memory access request.
- mem_write  out  1  write qualifier for mem_req.
- ir_write  out  1  load IR.
- pc_write  out  1  load PC.
- pc_src  out  2  PC source: 0 = PC+4, 1 = branch target, 2 = jump target, 3 = register rs.
- reg_write  out  1  register file write enable.
- reg_dst  out  1  destination is rd.
- mem_to_reg  out  1  writeback data comes from memory.
- jal  out  1  writeback targets $31 with the link value.
- alu_src  out  1  ALU B operand is the immediate.
- alu_op  out  2  {R_or_I, branch}.
- sftmd  out  1  shift instruction.
- retired  out  1  one-cycle pulse when an instruction completes.
- trap  out  1  sticky flag: illegal opcode or memory timeout.
- trap_cause  out  2  1 = illegal opcode, 2 = timeout.
- state  out  3  current state, for debug.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- While rst_n is low:
  - state = FETCH.
  - All registered fields and outputs are 0.
  - mem_req is forced low.
- State encoding: FETCH = 0, DECODE = 1, EXECUTE = 2, MEMORY = 3, WRITEBACK = 4, TRAP = 7.
- Instruction classes:
  - R-format: op = 0x00; jr when func = 0x08.
  - lw = 0x23, sw = 0x2B, beq = 0x04, bne = 0x05, j = 0x02, jal = 0x03.
  - I-format: op[5:3] = 3'b001.
  - Any other opcode is illegal.
  - sftmd = R-format and func is one of {0x00, 0x02, 0x03, 0x04, 0x06, 0x07}.
- Decode latching: opcode and func are captured into internal registers on the DECODE cycle. EXECUTE, MEMORY and WRITEBACK use only the latched copy, so IR changes after DECODE are ignored.
- FETCH:
  - mem_req = 1, mem_write = 0.
  - On the cycle mem_ready = 1: ir_write = 1, pc_write = 1, pc_src = 0, then go to DECODE.
  - Otherwise stay in FETCH.
- DECODE:
  - Illegal opcode: go to TRAP with cause 1.
  - j: pc_write = 1, pc_src = 2, retired = 1, go to FETCH.
  - jr: pc_write = 1, pc_src = 3, retired = 1, go to FETCH.
  - jal: go to WRITEBACK.
  - All other classes: go to EXECUTE.
- EXECUTE:
  - alu_src = I-format or lw or sw; alu_op as defined; sftmd valid.
  - beq/bne: pc_write = (beq & zero) | (bne & ~zero), pc_src = 1, retired = 1, go to FETCH.
  - lw/sw: go to MEMORY.
  - R-format and I-format: go to WRITEBACK.
- MEMORY:
  - mem_req = 1; mem_write = 1 for sw.
  - Wait for mem_ready.
  - lw: go to WRITEBACK.
  - sw: retired = 1, go to FETCH.
- WRITEBACK:
  - reg_write = 1 for exactly one cycle.
  - reg_dst = R-format; mem_to_reg = lw; jal = jal.
  - For jal, the same cycle also drives pc_write = 1, pc_src = 2.
  - retired = 1, then go to FETCH.
- Watchdog:
  - The counter clears on every state entry and increments each cycle spent in FETCH or MEMORY with mem_ready = 0.
  - If MEM_TIMEOUT ≠ 0 and the counter reaches MEM_TIMEOUT, go to TRAP with cause 2.
  - mem_ready arriving on that same cycle wins: no trap.
  - The counter saturates and never wraps.
- TRAP:
  - All enables are 0; trap = 1.
  - trap_cause holds; exit only via reset.
- Output timing: all enables except state are combinational from state, the latched decode, zero and mem_ready; pulses therefore align with the advancing edge.
- Latency with zero-wait memory:
  - j/jr: 2 cycles.
  - Branch: 3 cycles.
  - R-format, I-format, sw: 4 cycles.
  - jal: 3 cycles.
  - lw: 5 cycles.
- Reset mid-instruction aborts immediately. No partial write may occur on the cycle after rst_n rises; the FSM restarts in FETCH.

Test Plan:
- add (op = 0, func = 0x20), mem_ready always 1:
  - states 0 → 1 → 2 → 4 → 0.
  - reg_write = 1, reg_dst = 1 only in state 4.
  - retired pulses once at cycle 4.
- lw with mem_ready delayed 3 cycles in MEMORY:
  - mem_req held 4 cycles in state 3.
  - mem_to_reg = 1 and reg_write = 1 in state 4.
  - Total 8 cycles.
- beq, both cases:
  - zero = 1: pc_write = 1, pc_src = 1 in EXECUTE.
  - zero = 0: pc_write = 0 in EXECUTE.
  - bne with zero = 0: pc_write = 1.
- jal:
  - WRITEBACK cycle shows reg_write = 1, jal = 1, pc_write = 1, pc_src = 2.
  - jr (op = 0, func = 0x08): reg_write never asserted.
- Opcode 0x3F: TRAP entered after DECODE with trap_cause = 1, and it stays there for 50 cycles.
- Timeout:
  - MEM_TIMEOUT = 5, mem_ready held 0 in FETCH: TRAP with cause 2 after 5 wait cycles.
  - Repeat with mem_ready = 1 on the 5th cycle: no trap.
  - rst_n pulsed low mid-MEMORY: state = 0 and all outputs 0 asynchronously.
